fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: owns the PC register, drives the instruction-memory address, captures the fetched word into the IF/ID pipeline register, and computes the next PC from the decode-stage control decision. It sits directly upstream of the decoder/control unit, feeding it `id_instr[31:26]`/`id_instr[5:0]`, and consumes that unit's `NPCOp` back as `npc_op`. No branch delay slot: every taken redirect squashes the wrong-path fetch.

---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_npc_sel.sv | 41 ++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared control encodings for the fetch stage and the decoder.
//   npc_op_e      : next-PC select driven by control for the ID instruction
//   RESET_PC      : PC value loaded by reset
//   ifid_t        : IF/ID pipeline register contents
//   branch_offset : sign-extended, word-scaled branch displacement
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JUMP   = 2'b10,
      NPC_REG    = 2'b11
   } npc_op_e;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_npc_sel.sv
// Combinational next-PC mux and target arithmetic.
//   pc_i           : current PC
//   id_pc4_i       : PC+4 of the instruction in ID
//   id_instr_idx_i : low 26 bits of the ID instruction (jump index / branch imm)
//   npc_op_i       : next-PC select
//   jr_word_i      : register jump target, word address bits [31:2]
//   pc_plus4_o     : pc_i + 4 (sequential fetch)
//   npc_o          : selected next PC
// All arithmetic wraps modulo 2^32.
module npc_sel
   import fetch_stage_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] id_pc4_i,
   input  logic [25:0] id_instr_idx_i,
   input  npc_op_e     npc_op_i,
   input  logic [29:0] jr_word_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] npc_o
);

   logic [31:0] branch_tgt;
   logic [31:0] jump_tgt;

   assign pc_plus4_o = pc_i + 32'd4;
   assign branch_tgt = id_pc4_i + branch_offset(id_instr_idx_i[15:0]);
   // Jumps stay inside the 256 MB region of the delay-slot-free ID PC+4.
   assign jump_tgt   = {id_pc4_i[31:28], id_instr_idx_i, 2'b00};

   always_comb begin
      npc_o = pc_plus4_o;
      case (npc_op_i)
         NPC_PLUS4:  npc_o = pc_plus4_o;
         NPC_BRANCH: npc_o = branch_tgt;
         NPC_JUMP:   npc_o = jump_tgt;
         NPC_REG:    npc_o = {jr_word_i, 2'b00};
         default:    npc_o = pc_plus4_o;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID
// pipeline register and redirect/stall priority. No branch delay slot; a
// taken redirect flushes the wrong-path fetch into a bubble.
//   clk         : rising-edge clock
//   rstn        : synchronous active-low reset
//   stall       : load-use hold, freezes PC and IF/ID
//   npc_op      : next-PC select for the instruction in ID
//   jr_target   : forwarded rs value for jr/jalr
//   im_dout     : instruction word at im_addr (asynchronous read)
//   im_addr     : current PC
//   id_instr    : IF/ID instruction
//   id_pc4      : IF/ID PC+4 (also the link value)
//   id_valid    : IF/ID holds a real instruction
//   jr_misalign : one-cycle pulse on a REG redirect with nonzero target[1:0]
module fetch_stage
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic [1:0]  npc_op,
   input  logic [31:0] jr_target,
   input  logic [31:0] im_dout,
   output logic [31:0] im_addr,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic        jr_misalign
);

   logic [31:0] pc_q, pc_d;
   ifid_t       ifid_q, ifid_d;
   logic        jr_mis_q, jr_mis_d;

   npc_op_e     op;
   logic        redirect;
   logic [31:0] pc_plus4;
   logic [31:0] npc;

   assign op = npc_op_e'(npc_op);
   // Bubbles carry a don't-care npc_op, so only a valid ID instruction redirects.
   assign redirect = ifid_q.valid & (op != NPC_PLUS4) & ~stall;

   npc_sel u_npc_sel (
      .pc_i           (pc_q),
      .id_pc4_i       (ifid_q.pc4),
      .id_instr_idx_i (ifid_q.instr[25:0]),
      .npc_op_i       (op),
      .jr_word_i      (jr_target[31:2]),
      .pc_plus4_o     (pc_plus4),
      .npc_o          (npc)
   );

   always_comb begin
      pc_d     = pc_q;
      ifid_d   = ifid_q;
      jr_mis_d = 1'b0;
      if (stall) begin
         pc_d   = pc_q;
         ifid_d = ifid_q;
      end else if (redirect) begin
         pc_d     = npc;
         ifid_d   = IFID_BUBBLE;
         jr_mis_d = (op == NPC_REG) & (jr_target[1:0] != 2'b00);
      end else begin
         pc_d         = pc_plus4;
         ifid_d.instr = im_dout;
         ifid_d.pc4   = pc_plus4;
         ifid_d.valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q     <= RESET_PC;
         ifid_q   <= IFID_BUBBLE;
         jr_mis_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ifid_q   <= ifid_d;
         jr_mis_q <= jr_mis_d;
      end
   end

   assign im_addr     = pc_q;
   assign id_instr    = ifid_q.instr;
   assign id_pc4      = ifid_q.pc4;
   assign id_valid    = ifid_q.valid;
   assign jr_misalign = jr_mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk;
   logic        rstn;
   logic        stall;
   logic [1:0]  npc_op;
   logic [31:0] jr_target;
   logic [31:0] im_dout;
   logic [31:0] im_addr;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic        jr_misalign;

   fetch_stage dut (
      .clk         (clk),
      .rstn        (rstn),
      .stall       (stall),
      .npc_op      (npc_op),
      .jr_target   (jr_target),
      .im_dout     (im_dout),
      .im_addr     (im_addr),
      .id_instr    (id_instr),
      .id_pc4      (id_pc4),
      .id_valid    (id_valid),
      .jr_misalign (jr_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] W_A = 32'h1111_0001;
   localparam logic [31:0] W_B = 32'h2222_0002;
   localparam logic [31:0] W_C = 32'h3333_0003;

   logic [31:0] w_300c;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memw(input logic [31:0] a);
      if (a == 32'h0000_3000) return W_A;
      if (a == 32'h0000_3004) return W_B;
      if (a == 32'h0000_3008) return W_C;
      if (a == 32'h0000_300C) return w_300c;
      return {8'hEE, a[23:0]};
   endfunction

   // Reference model of one rising edge, expected state pushed to the scoreboard.
   task automatic model_edge();
      logic [31:0] word, tgt;
      exp_t e;
      word = memw(m_pc);
      if (!rstn) begin
         m_pc = 32'h0000_3000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
      end else if (stall) begin
         m_mis = 0;
      end else if (m_valid && npc_op != 2'b00) begin
         case (npc_op)
            2'b01:   tgt = m_pc4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
            2'b10:   tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
            default: tgt = {jr_target[31:2], 2'b00};
         endcase
         m_mis = (npc_op == 2'b11) && (jr_target[1:0] != 2'b00);
         m_pc = tgt; m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else begin
         m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4; m_mis = 0;
      end
      e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, mis: m_mis};
      exp_q.push_back(e);
   endtask

   task automatic step(input string tag);
      exp_t e;
      im_dout = memw(im_addr);
      model_edge();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".pc"},    im_addr, e.pc);
         chk({tag, ".instr"}, id_instr, e.instr);
         chk({tag, ".pc4"},   id_pc4, e.pc4);
         chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, e.valid});
         chk({tag, ".mis"},   {31'd0, jr_misalign}, {31'd0, e.mis});
      end
   endtask

   initial begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
      w_300c    = 32'h1000_FFFC;
      rstn      = 1'b0;
      stall     = 1'b0;
      npc_op    = 2'b00;
      jr_target = 32'h0;
      im_dout   = 32'h0;

      step("reset");
      chk("reset.addr", im_addr, 32'h0000_3000);
      rstn = 1'b1;
      step("seq1"); chk("seq1.instrA", id_instr, W_A); chk("seq1.addr", im_addr, 32'h0000_3004);
      step("seq2"); chk("seq2.instrB", id_instr, W_B); chk("seq2.pc4", id_pc4, 32'h0000_3008);
      step("seq3"); chk("seq3.instrC", id_instr, W_C); chk("seq3.addr", im_addr, 32'h0000_300C);
      step("seq4"); chk("seq4.pc4", id_pc4, 32'h0000_3010);

      npc_op = 2'b01;
      step("br");   chk("br.target", im_addr, 32'h0000_3000); chk("br.bubble", {31'd0, id_valid}, 32'd0);
      npc_op = 2'b11;  // ignored while ID holds a bubble
      step("br_bubble"); chk("br_bubble.addr", im_addr, 32'h0000_3004);
      npc_op = 2'b00;
      chk("br_bubble.instrA", id_instr, W_A);

      w_300c = 32'h0800_0C04;
      step("j1"); step("j2"); step("j3");
      npc_op = 2'b10;
      step("jump"); chk("jump.target", im_addr, 32'h0000_3010);
      npc_op = 2'b00;
      step("j_fetch");

      npc_op = 2'b11; jr_target = 32'h0000_3023;
      step("jr"); chk("jr.target", im_addr, 32'h0000_3020); chk("jr.mis", {31'd0, jr_misalign}, 32'd1);
      npc_op = 2'b00;
      step("jr_after"); chk("jr_after.mis", {31'd0, jr_misalign}, 32'd0);

      stall = 1'b1; npc_op = 2'b01;
      step("stall1"); chk("stall1.addr", im_addr, 32'h0000_3024);
      step("stall2"); chk("stall2.addr", im_addr, 32'h0000_3024); chk("stall2.pc4", id_pc4, 32'h0000_3024);
      stall = 1'b0;
      step("unstall"); chk("unstall.target", im_addr, 32'h0000_F0A4);
      npc_op = 2'b00;
      step("refill");

      rstn = 1'b0; stall = 1'b1; npc_op = 2'b11; jr_target = 32'h0000_3023;
      step("mid_rst"); chk("mid_rst.addr", im_addr, 32'h0000_3000); chk("mid_rst.valid", {31'd0, id_valid}, 32'd0);
      rstn = 1'b1; stall = 1'b0; npc_op = 2'b00;
      step("post_rst"); chk("post_rst.instrA", id_instr, W_A);

      npc_op = 2'b11; jr_target = 32'hFFFF_FFFC;
      step("to_top"); chk("to_top.addr", im_addr, 32'hFFFF_FFFC);
      npc_op = 2'b00;
      step("wrap"); chk("wrap.addr", im_addr, 32'h0000_0000); chk("wrap.pc4", id_pc4, 32'h0000_0000);

      for (int i = 0; i < 60; i++) begin
         stall     = ($urandom_range(0, 3) == 0);
         npc_op    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         jr_target = $urandom;
         rstn      = ($urandom_range(0, 29) != 0);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
